alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
Multi-cycle shift-add multiplier sequencer that drives the shared 32-bit ALU through its data1/data2/aluop/alu_result/zero interface to compute the low XLEN bits of a*b. One ALU operation is issued per cycle: ADD, SLL, or SRL. It sits beside the execute stage. It accepts requests over a valid/ready handshake and returns the product over a second valid/ready handshake. It contains no adder or shifter of its own; all arithmetic goes through the ALU.

Parameters:
XLEN, 32, operand/product width; must match the ALU data width.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_a  input  XLEN  multiplicand
req_b  input  XLEN  multiplier
rsp_valid  output  1  product valid (high only in DONE)
rsp_ready  input  1  consumer accepts product
rsp_product  output  XLEN  low XLEN bits of a*b (the acc register)
alu_busy  output  1  block owns the ALU this cycle (ADD/SHL/SHR states)
alu_data1  output  XLEN  ALU operand 1
alu_data2  output  XLEN  ALU operand 2
alu_op  output  4  ALU opcode: AND=0000, ADD=0010, SLL=0101, SRL=0110
alu_result  input  XLEN  ALU result (combinational)
alu_zero  input  1  ALU zero flag (alu_result==0)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc, mcand and mplr cleared. Outputs: req_ready=1, rsp_valid=0, rsp_product=0, alu_busy=0, alu_op=AND, alu_data1=0, alu_data2=0.
- Reset mid-operation aborts the operation and discards it; no response is produced.
- Registers: acc, mcand, mplr (XLEN each); state is one of IDLE, ADD, SHL, SHR, DONE.
- IDLE: req_ready=1. On req_valid:
  - latch mcand=req_a, mplr=req_b, acc=0;
  - next state = DONE if req_b==0, else ADD if req_b[0]=1, else SHL.
- ADD: alu_op=ADD, data1=acc, data2=mcand; acc<=alu_result; next state SHL.
- SHL: alu_op=SLL, data1=mcand, data2=1; mcand<=alu_result; next state SHR.
- SHR: alu_op=SRL, data1=mplr, data2=1; mplr<=alu_result.
  - Next state = DONE if alu_zero, else ADD if alu_result[0], else SHL.
- DONE: rsp_valid=1, rsp_product=acc, held stable until rsp_ready. On rsp_ready go to IDLE.
  - req_ready is 0 in DONE, so a new request is accepted no earlier than the following IDLE cycle.
- In IDLE and DONE: alu_busy=0 and the ALU outputs are driven to AND/0/0.
- Latency: let n = index of the highest set bit of b, plus 1, and p = popcount(b). Then L = 2n + p.
  - rsp_valid rises L clock edges after the accepting edge, except b=0, where it rises at the accepting edge itself (visible in the next cycle).
  - Maximum L = 96 for XLEN=32.
- Arithmetic wraps modulo 2^XLEN; overflow is silently discarded.
- req_a/req_b are sampled only at acceptance; later changes to them have no effect.

Optional Feature:
Macro ALU_SHARE_EN.
- Defined: adds input port alu_gnt (1 bit). In ADD/SHL/SHR, registers update and state advances only in cycles where alu_gnt=1. While alu_gnt=0 the state holds, alu_busy stays 1, and the ALU outputs hold. Each stalled cycle adds one cycle to L.
- Undefined: no alu_gnt port; behaves as if alu_gnt=1.

Test Plan:
1. a=3, b=5 -> rsp_product=0x0000000F; rsp_valid 8 edges after acceptance; alu_op sequence ADD,SLL,SRL,SLL,SRL,ADD,SLL,SRL.
2. a=0xDEADBEEF, b=0 -> rsp_product=0; rsp_valid in the cycle after acceptance; alu_busy never asserts.
3. a=0xFFFFFFFF, b=0xFFFFFFFF -> rsp_product=0x00000001; L=96. Also a=0x00010000, b=0x00010000 -> product 0 (wrap); L=35.
4. Start 7*6; pull rst_n low during the first SHL -> immediately rsp_valid=0, req_ready=1, alu_busy=0, rsp_product=0. Release reset and issue 7*6 -> product 0x2A after 8 edges.
5. Hold rsp_ready=0 for 5 cycles in DONE with req_valid=1 and different operands -> rsp_valid and rsp_product stay stable and req_ready=0. Release rsp_ready -> the new request is accepted in the next IDLE cycle.
6. With ALU_SHARE_EN: 3*5 with alu_gnt=0 for 3 cycles during the first ADD -> product 0x0F, L=11, and alu_data1/data2/alu_op are stable throughout the stall.

Source files
------------

// File: rtl/alu_mul_seq_if.sv
// Request/response handshakes plus the shared-ALU operand/result bus of the shift-add multiplier.
// Latency: none, wires only.
// Backpressure: carried by req_ready/rsp_ready; the ALU side is combinational.
interface alu_mul_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_product;
    logic            alu_busy;
    logic [XLEN-1:0] alu_data1;
    logic [XLEN-1:0] alu_data2;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    // Multiplier side: consumes requests and ALU results, drives responses and ALU operands.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, alu_result, alu_zero,
        output req_ready, rsp_valid, rsp_product, alu_busy, alu_data1, alu_data2, alu_op
    );

    // Environment side: requester, consumer and the ALU itself.
    modport master (
        output req_valid, req_a, req_b, rsp_ready, alu_result, alu_zero,
        input  req_ready, rsp_valid, rsp_product, alu_busy, alu_data1, alu_data2, alu_op
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier (low XLEN bits of a*b) that borrows the shared ALU: one ADD/SLL/SRL per cycle.
// Latency: 2n+popcount(b) edges after acceptance (n = msb index of b + 1); b==0 answers at the accept edge.
// Backpressure: req_ready only in IDLE; product held in DONE until rsp_ready. Optional macro ALU_SHARE_EN adds alu_gnt stall input.
module alu_mul_seq #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef ALU_SHARE_EN
    input  logic         alu_gnt,
`endif
    alu_mul_seq_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} state_t;

    localparam logic [3:0]      OP_AND = 4'b0000;
    localparam logic [3:0]      OP_ADD = 4'b0010;
    localparam logic [3:0]      OP_SLL = 4'b0101;
    localparam logic [3:0]      OP_SRL = 4'b0110;
    localparam logic [XLEN-1:0] ONE    = {{(XLEN-1){1'b0}}, 1'b1};

    state_t          state;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplr;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            busy_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] data1_q;
    logic [XLEN-1:0] data2_q;
    logic            step;

    // The ALU is ours every cycle unless an arbiter can withhold it.
`ifdef ALU_SHARE_EN
    assign step = alu_gnt;
`else
    assign step = 1'b1;
`endif

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_product = acc;
    assign bus.alu_busy    = busy_q;
    assign bus.alu_op      = op_q;
    assign bus.alu_data1   = data1_q;
    assign bus.alu_data2   = data2_q;

    // Sequencer: ALU operands are registered one cycle ahead, built from the values the next state will use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            acc         <= '0;
            mcand       <= '0;
            mplr        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_q        <= OP_AND;
            data1_q     <= '0;
            data2_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        mcand       <= bus.req_a;
                        mplr        <= bus.req_b;
                        acc         <= '0;
                        req_ready_q <= 1'b0;
                        if (bus.req_b == '0) begin
                            state       <= S_DONE;
                            rsp_valid_q <= 1'b1;
                        end else if (bus.req_b[0]) begin
                            state   <= S_ADD;
                            busy_q  <= 1'b1;
                            op_q    <= OP_ADD;
                            data1_q <= '0;
                            data2_q <= bus.req_a;
                        end else begin
                            state   <= S_SHL;
                            busy_q  <= 1'b1;
                            op_q    <= OP_SLL;
                            data1_q <= bus.req_a;
                            data2_q <= ONE;
                        end
                    end
                end
                S_ADD: begin
                    if (step) begin
                        acc     <= bus.alu_result;
                        state   <= S_SHL;
                        op_q    <= OP_SLL;
                        data1_q <= mcand;
                        data2_q <= ONE;
                    end
                end
                S_SHL: begin
                    if (step) begin
                        mcand   <= bus.alu_result;
                        state   <= S_SHR;
                        op_q    <= OP_SRL;
                        data1_q <= mplr;
                        data2_q <= ONE;
                    end
                end
                S_SHR: begin
                    if (step) begin
                        mplr <= bus.alu_result;
                        if (bus.alu_zero) begin
                            state       <= S_DONE;
                            busy_q      <= 1'b0;
                            op_q        <= OP_AND;
                            data1_q     <= '0;
                            data2_q     <= '0;
                            rsp_valid_q <= 1'b1;
                        end else if (bus.alu_result[0]) begin
                            state   <= S_ADD;
                            op_q    <= OP_ADD;
                            data1_q <= acc;
                            data2_q <= mcand;
                        end else begin
                            state   <= S_SHL;
                            op_q    <= OP_SLL;
                            data1_q <= mcand;
                            data2_q <= ONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        state       <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    op_q        <= OP_AND;
                    data1_q     <= '0;
                    data2_q     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU attached to the operand bus.
// Latency: measured in clock edges from the accepting edge to rsp_valid.
// Backpressure: rsp_ready is held low to check the DONE hold, pulsed to drain.
module tb_alu_mul_seq;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;

    logic clk;
    logic rst_n;
`ifdef ALU_SHARE_EN
    logic alu_gnt;
`endif

    alu_mul_seq_if #(.XLEN(32)) ifc ();

    alu_mul_seq #(.XLEN(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef ALU_SHARE_EN
        .alu_gnt (alu_gnt),
`endif
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        ifc.alu_result = '0;
        case (ifc.alu_op)
            OP_AND:  ifc.alu_result = ifc.alu_data1 & ifc.alu_data2;
            OP_ADD:  ifc.alu_result = ifc.alu_data1 + ifc.alu_data2;
            OP_SLL:  ifc.alu_result = ifc.alu_data1 << ifc.alu_data2[4:0];
            OP_SRL:  ifc.alu_result = ifc.alu_data1 >> ifc.alu_data2[4:0];
            default: ifc.alu_result = '0;
        endcase
    end
    assign ifc.alu_zero = (ifc.alu_result == '0);

    int         n_vec;
    int         n_bad;
    int         lat;
    logic       busy_seen;
    logic [3:0] ops_q[$];

    // Issue one request from IDLE and count edges until rsp_valid (bounded).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        int g;
        g = 0;
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_a     = a;
        ifc.req_b     = b;
        while (!ifc.req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        lat       = 0;
        busy_seen = 1'b0;
        ops_q.delete();
        while (!ifc.rsp_valid && lat < 300) begin
            if (ifc.alu_busy) begin
                busy_seen = 1'b1;
                ops_q.push_back(ifc.alu_op);
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++; if (ifc.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=1", ifc.req_ready); end
        n_vec++; if (ifc.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", ifc.rsp_valid); end
        n_vec++; if (ifc.rsp_product !== 32'h0) begin n_bad++; $display("FAIL reset_product got=%h exp=0", ifc.rsp_product); end
        n_vec++; if (ifc.alu_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", ifc.alu_busy); end
        n_vec++; if (ifc.alu_op !== OP_AND) begin n_bad++; $display("FAIL reset_op got=%h exp=0", ifc.alu_op); end
        n_vec++; if (ifc.alu_data1 !== 32'h0 || ifc.alu_data2 !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%h/%h exp=0/0", ifc.alu_data1, ifc.alu_data2); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] exp_ops [8];
        exp_ops = '{OP_ADD, OP_SLL, OP_SRL, OP_SLL, OP_SRL, OP_ADD, OP_SLL, OP_SRL};
        run_op(32'd3, 32'd5);
        n_vec++; if (ifc.rsp_product !== 32'h0000000F) begin n_bad++; $display("FAIL basic_3x5_product got=%h exp=0000000f", ifc.rsp_product); end
        n_vec++; if (lat != 8) begin n_bad++; $display("FAIL basic_3x5_latency got=%0d exp=8", lat); end
        n_vec++; if (ops_q.size() != 8) begin n_bad++; $display("FAIL basic_3x5_opcount got=%0d exp=8", ops_q.size()); end
        for (int i = 0; i < 8 && i < ops_q.size(); i++) begin
            n_vec++;
            if (ops_q[i] !== exp_ops[i]) begin n_bad++; $display("FAIL basic_3x5_op[%0d] got=%h exp=%h", i, ops_q[i], exp_ops[i]); end
        end
        drain();
        run_op(32'd7, 32'd6);
        n_vec++; if (ifc.rsp_product !== 32'h0000002A) begin n_bad++; $display("FAIL basic_7x6_product got=%h exp=0000002a", ifc.rsp_product); end
        n_vec++; if (lat != 8) begin n_bad++; $display("FAIL basic_7x6_latency got=%0d exp=8", lat); end
        drain();
    endtask

    task automatic test_zero();
        run_op(32'hDEADBEEF, 32'h0);
        n_vec++; if (ifc.rsp_product !== 32'h0) begin n_bad++; $display("FAIL zero_product got=%h exp=0", ifc.rsp_product); end
        n_vec++; if (lat != 0) begin n_bad++; $display("FAIL zero_latency got=%0d exp=0", lat); end
        n_vec++; if (busy_seen !== 1'b0 || ifc.alu_busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy got=%b exp=0", busy_seen | ifc.alu_busy); end
        drain();
    endtask

    task automatic test_boundary();
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF);
        n_vec++; if (ifc.rsp_product !== 32'h00000001) begin n_bad++; $display("FAIL max_product got=%h exp=00000001", ifc.rsp_product); end
        n_vec++; if (lat != 96) begin n_bad++; $display("FAIL max_latency got=%0d exp=96", lat); end
        drain();
        run_op(32'h00010000, 32'h00010000);
        n_vec++; if (ifc.rsp_product !== 32'h0) begin n_bad++; $display("FAIL wrap_product got=%h exp=0", ifc.rsp_product); end
        n_vec++; if (lat != 35) begin n_bad++; $display("FAIL wrap_latency got=%0d exp=35", lat); end
        drain();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_a     = 32'd7;
        ifc.req_b     = 32'd6;
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        n_vec++; if (ifc.alu_op !== OP_SLL || ifc.alu_busy !== 1'b1) begin n_bad++; $display("FAIL midrst_in_shl got op=%h busy=%b exp op=5 busy=1", ifc.alu_op, ifc.alu_busy); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (ifc.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_rsp_valid got=%b exp=0", ifc.rsp_valid); end
        n_vec++; if (ifc.req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_req_ready got=%b exp=1", ifc.req_ready); end
        n_vec++; if (ifc.alu_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", ifc.alu_busy); end
        n_vec++; if (ifc.rsp_product !== 32'h0) begin n_bad++; $display("FAIL midrst_product got=%h exp=0", ifc.rsp_product); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd7, 32'd6);
        n_vec++; if (ifc.rsp_product !== 32'h0000002A) begin n_bad++; $display("FAIL midrst_redo_product got=%h exp=0000002a", ifc.rsp_product); end
        n_vec++; if (lat != 8) begin n_bad++; $display("FAIL midrst_redo_latency got=%0d exp=8", lat); end
        drain();
    endtask

    task automatic test_back_to_back();
        int l2;
        run_op(32'd3, 32'd5);
        ifc.req_valid = 1'b1;
        ifc.req_a     = 32'd9;
        ifc.req_b     = 32'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (ifc.rsp_valid !== 1'b1 || ifc.rsp_product !== 32'h0000000F || ifc.req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_cycle%0d got valid=%b prod=%h rdy=%b exp 1/0000000f/0", i, ifc.rsp_valid, ifc.rsp_product, ifc.req_ready);
            end
        end
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.rsp_ready = 1'b0;
        n_vec++; if (ifc.req_ready !== 1'b1 || ifc.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got rdy=%b valid=%b exp 1/0", ifc.req_ready, ifc.rsp_valid); end
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        n_vec++; if (ifc.alu_busy !== 1'b1 || ifc.alu_op !== OP_SLL || ifc.alu_data1 !== 32'd9) begin n_bad++; $display("FAIL b2b_accept got busy=%b op=%h d1=%h exp 1/5/00000009", ifc.alu_busy, ifc.alu_op, ifc.alu_data1); end
        l2 = 0;
        while (!ifc.rsp_valid && l2 < 300) begin
            @(posedge clk);
            #1;
            l2++;
        end
        n_vec++; if (ifc.rsp_product !== 32'd18) begin n_bad++; $display("FAIL b2b_product got=%h exp=00000012", ifc.rsp_product); end
        n_vec++; if (l2 != 5) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=5", l2); end
        drain();
    endtask

`ifdef ALU_SHARE_EN
    task automatic test_share();
        int l3;
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_a     = 32'd3;
        ifc.req_b     = 32'd5;
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        alu_gnt       = 1'b0;
        l3 = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            l3++;
            n_vec++;
            if (ifc.alu_op !== OP_ADD || ifc.alu_data1 !== 32'd0 || ifc.alu_data2 !== 32'd3 || ifc.alu_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL share_stall%0d got op=%h d1=%h d2=%h busy=%b exp 2/0/3/1", i, ifc.alu_op, ifc.alu_data1, ifc.alu_data2, ifc.alu_busy);
            end
        end
        alu_gnt = 1'b1;
        while (!ifc.rsp_valid && l3 < 300) begin
            @(posedge clk);
            #1;
            l3++;
        end
        n_vec++; if (ifc.rsp_product !== 32'h0000000F) begin n_bad++; $display("FAIL share_product got=%h exp=0000000f", ifc.rsp_product); end
        n_vec++; if (l3 != 11) begin n_bad++; $display("FAIL share_latency got=%0d exp=11", l3); end
        drain();
    endtask
`endif

    initial begin
        n_vec         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.rsp_ready = 1'b0;
`ifdef ALU_SHARE_EN
        alu_gnt       = 1'b1;
`endif
        test_reset();
        test_basic();
        test_zero();
        test_boundary();
        test_reset_mid();
        test_back_to_back();
`ifdef ALU_SHARE_EN
        test_share();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
